// File: rtl/mist_video_pkg.sv
// Shared video definitions for the MiST blanking generator.
// Holds the horizontal FSM state encoding and the default datapath widths.
package mist_video_pkg;

  localparam int unsigned DEF_COLOR_DEPTH = 6;
  localparam int unsigned DEF_HCNT_WIDTH  = 10;
  localparam int unsigned DEF_VCNT_WIDTH  = 9;

  typedef enum logic [1:0] {
    H_SYNC   = 2'd0,
    H_BACK   = 2'd1,
    H_ACTIVE = 2'd2,
    H_FRONT  = 2'd3
  } h_state_t;

endpackage

// File: rtl/mist_sync_pol.sv
// Sync polarity detector.
// Measures the high time of a sync signal against its period (rising edge to
// rising edge, counted in en strobes). A sync that is high for less than half
// of its period is reported as active-high.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          sample strobe (pixel enable, or one strobe per line)
//   sync_in     raw sync input
//   act_high    registered result, 1 = sync is active-high
module mist_sync_pol #(
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_in,
  output logic act_high
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 prev;
  logic                 rise_c;
  logic [CNT_WIDTH-1:0] high_cnt;
  logic [CNT_WIDTH-1:0] per_cnt;

  assign rise_c = sync_in & ~prev;

  // Period/high-time counters; decision taken at each raw rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b0;
      high_cnt <= '0;
      per_cnt  <= '0;
      act_high <= 1'b0;
    end else if (en) begin
      prev <= sync_in;
      if (rise_c) begin
        act_high <= ({high_cnt, 1'b0} < {1'b0, per_cnt});
        high_cnt <= CNT_WIDTH'(1);
        per_cnt  <= CNT_WIDTH'(1);
      end else begin
        if (sync_in && (high_cnt != CNT_MAX)) high_cnt <= high_cnt + CNT_WIDTH'(1);
        if (per_cnt != CNT_MAX)               per_cnt  <= per_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mist_blank_gen.sv
// Blanking generator for MiST video cores.
// Derives hblank/vblank windows from the core syncs and programmable
// start/end positions, blanks the colour outputs and re-emits active-low
// syncs, all with one ce_pix of latency.
// Optional feature: define MIST_BLANK_GEN_POLARITY_DETECT_EN to detect sync
// polarity automatically; otherwise hs_in/vs_in are taken as active-low.
// Ports:
//   clk_sys, reset_n          clock, async active-low reset
//   ce_pix                    pixel enable
//   hs_in, vs_in, r/g/b_in    core video
//   h_start, h_end            active pixel window (from hsync leading edge)
//   v_start, v_end            active line window (from vsync leading edge)
//   r/g/b_out, hs_out, vs_out blanked video, active-low syncs
//   hblank, vblank            active-high blanking
//   line_len                  ce_pix count of the last complete line
module mist_blank_gen
  import mist_video_pkg::*;
#(
  parameter int unsigned COLOR_DEPTH = DEF_COLOR_DEPTH,
  parameter int unsigned HCNT_WIDTH  = DEF_HCNT_WIDTH,
  parameter int unsigned VCNT_WIDTH  = DEF_VCNT_WIDTH
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ce_pix,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic [COLOR_DEPTH-1:0] r_in,
  input  logic [COLOR_DEPTH-1:0] g_in,
  input  logic [COLOR_DEPTH-1:0] b_in,
  input  logic [HCNT_WIDTH-1:0]  h_start,
  input  logic [HCNT_WIDTH-1:0]  h_end,
  input  logic [VCNT_WIDTH-1:0]  v_start,
  input  logic [VCNT_WIDTH-1:0]  v_end,
  output logic [COLOR_DEPTH-1:0] r_out,
  output logic [COLOR_DEPTH-1:0] g_out,
  output logic [COLOR_DEPTH-1:0] b_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   hblank,
  output logic                   vblank,
  output logic [HCNT_WIDTH-1:0]  line_len
);

  localparam logic [HCNT_WIDTH-1:0] HCNT_MAX = '1;
  localparam logic [VCNT_WIDTH-1:0] VCNT_MAX = '1;

  logic                  hs_pol_high;
  logic                  vs_pol_high;
  logic                  hs_act_c;
  logic                  vs_act_c;
  logic                  hs_prev;
  logic                  vs_prev;
  logic                  hs_lead_c;
  logic                  vs_lead_c;
  logic [HCNT_WIDTH-1:0] hcnt;
  logic [HCNT_WIDTH-1:0] hcnt_nxt_c;
  logic [VCNT_WIDTH-1:0] vcnt;
  logic [VCNT_WIDTH-1:0] vcnt_nxt_c;
  h_state_t              state;
  h_state_t              state_nxt_c;
  logic                  hblank_c;
  logic                  vblank_c;
  logic                  blank_c;

`ifdef MIST_BLANK_GEN_POLARITY_DETECT_EN
  // hsync measured per pixel, vsync measured per line.
  mist_sync_pol #(.CNT_WIDTH(HCNT_WIDTH)) u_hs_pol (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .en       (ce_pix),
    .sync_in  (hs_in),
    .act_high (hs_pol_high)
  );

  mist_sync_pol #(.CNT_WIDTH(VCNT_WIDTH)) u_vs_pol (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .en       (ce_pix & hs_lead_c),
    .sync_in  (vs_in),
    .act_high (vs_pol_high)
  );
`else
  assign hs_pol_high = 1'b0;
  assign vs_pol_high = 1'b0;
`endif

  // Normalised syncs: 1 = sync asserted.
  assign hs_act_c = hs_pol_high ? hs_in : ~hs_in;
  assign vs_act_c = vs_pol_high ? vs_in : ~vs_in;

  // Counters and horizontal state for the pixel currently on the inputs.
  always_comb begin
    hs_lead_c = hs_act_c & ~hs_prev;
    vs_lead_c = vs_act_c & ~vs_prev;

    hcnt_nxt_c = hcnt;
    if (hs_lead_c)             hcnt_nxt_c = '0;
    else if (hcnt != HCNT_MAX) hcnt_nxt_c = hcnt + HCNT_WIDTH'(1);

    vcnt_nxt_c = vcnt;
    if (vs_lead_c)                         vcnt_nxt_c = '0;
    else if (hs_lead_c && vcnt != VCNT_MAX) vcnt_nxt_c = vcnt + VCNT_WIDTH'(1);

    // Chained so that back porch / active boundaries can fall on any pixel.
    state_nxt_c = state;
    if (hs_lead_c) state_nxt_c = H_SYNC;
    if (state_nxt_c == H_SYNC && !hs_act_c) state_nxt_c = H_BACK;
    if (state_nxt_c == H_BACK && hcnt_nxt_c == h_start)
      state_nxt_c = (h_end > h_start) ? H_ACTIVE : H_FRONT;
    if (state_nxt_c == H_ACTIVE && hcnt_nxt_c == h_end) state_nxt_c = H_FRONT;
    // A lost hsync must not leave the active window open.
    if (state_nxt_c == H_ACTIVE && hcnt_nxt_c == HCNT_MAX) state_nxt_c = H_FRONT;

    hblank_c = (state_nxt_c != H_ACTIVE) || (h_end <= h_start);
    vblank_c = !((vcnt_nxt_c >= v_start) && (vcnt_nxt_c < v_end));
    blank_c  = hblank_c | vblank_c;
  end

  // State, counters and all outputs advance only on ce_pix.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev  <= 1'b1;
      vs_prev  <= 1'b1;
      hcnt     <= '0;
      vcnt     <= '0;
      state    <= H_FRONT;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
      hs_out   <= 1'b1;
      vs_out   <= 1'b1;
      hblank   <= 1'b1;
      vblank   <= 1'b1;
      line_len <= '0;
    end else if (ce_pix) begin
      hs_prev <= hs_act_c;
      vs_prev <= vs_act_c;
      hcnt    <= hcnt_nxt_c;
      vcnt    <= vcnt_nxt_c;
      state   <= state_nxt_c;
      r_out   <= blank_c ? '0 : r_in;
      g_out   <= blank_c ? '0 : g_in;
      b_out   <= blank_c ? '0 : b_in;
      hs_out  <= ~hs_act_c;
      vs_out  <= ~vs_act_c;
      hblank  <= hblank_c;
      vblank  <= vblank_c;
      if (hs_lead_c && hcnt != HCNT_MAX) line_len <= hcnt + HCNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mist_blank_gen.sv
// Directed self-checking bench for mist_blank_gen.
module tb_mist_blank_gen;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix  = 1'b0;
  logic       hs_in   = 1'b1;
  logic       vs_in   = 1'b1;
  logic [5:0] r_in    = 6'h2A;
  logic [5:0] g_in    = 6'h15;
  logic [5:0] b_in    = 6'h3F;
  logic [9:0] h_start = 10'd144;
  logic [9:0] h_end   = 10'd784;
  logic [8:0] v_start = 9'd0;
  logic [8:0] v_end   = 9'd500;
  logic [5:0] r_out, g_out, b_out;
  logic       hs_out, vs_out, hblank, vblank;
  logic [9:0] line_len;

  int checks = 0;
  int errors = 0;
  int act_cnt, hsl_cnt, col_nz;
  logic [5:0] r_at;
  logic       vb_at, vs_at;

  mist_blank_gen dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ce_pix   (ce_pix),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .h_start  (h_start),
    .h_end    (h_end),
    .v_start  (v_start),
    .v_end    (v_end),
    .r_out    (r_out),
    .g_out    (g_out),
    .b_out    (b_out),
    .hs_out   (hs_out),
    .vs_out   (vs_out),
    .hblank   (hblank),
    .vblank   (vblank),
    .line_len (line_len)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one line: sync asserted for the first sync_len pixels.
  task automatic run_line(input int len, input int sync_len, input logic inv, input logic vs);
    act_cnt = 0;
    hsl_cnt = 0;
    col_nz  = 0;
    for (int i = 0; i < len; i++) begin
      hs_in  = (i < sync_len) ? inv : ~inv;
      vs_in  = vs;
      ce_pix = 1'b1;
      @(posedge clk_sys);
      #1;
      if (!hblank) act_cnt++;
      if (!hs_out) hsl_cnt++;
      if (r_out != 6'd0 || g_out != 6'd0 || b_out != 6'd0) col_nz++;
      if (i == 400) begin
        r_at  = r_out;
        vb_at = vblank;
        vs_at = vs_out;
      end
    end
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_r_out", 32'(r_out), 32'd0);
    check("rst_hs_out", 32'(hs_out), 32'd1);
    check("rst_vs_out", 32'(vs_out), 32'd1);
    check("rst_hblank", 32'(hblank), 32'd1);
    check("rst_vblank", 32'(vblank), 32'd1);
    check("rst_line_len", 32'(line_len), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    // 800-pixel lines, 96 sync, window 144..784
    run_line(10, 0, 1'b0, 1'b1);
    run_line(800, 96, 1'b0, 1'b1);
    run_line(800, 96, 1'b0, 1'b1);
    check("std_active", 32'(act_cnt), 32'd640);
    check("std_hs_low", 32'(hsl_cnt), 32'd96);
    check("std_colour", 32'(r_at), 32'h2A);
    check("std_col_cnt", 32'(col_nz), 32'd640);
    run_line(800, 96, 1'b0, 1'b1);
    check("std_line_len", 32'(line_len), 32'd800);

    // Vertical window 5..9; vcnt is 4 on the next line, then 5
    v_start = 9'd5;
    v_end   = 9'd9;
    run_line(800, 96, 1'b0, 1'b1);
    check("vb_line4", 32'(vb_at), 32'd1);
    check("vb_line4_col", 32'(r_at), 32'd0);
    run_line(800, 96, 1'b0, 1'b1);
    check("vb_line5", 32'(vb_at), 32'd0);
    check("vb_line5_col", 32'(r_at), 32'h2A);
    run_line(800, 96, 1'b0, 1'b0);
    check("vs_clear_vb", 32'(vb_at), 32'd1);
    check("vs_out_low", 32'(vs_at), 32'd0);
    run_line(800, 96, 1'b0, 1'b1);
    check("vs_out_high", 32'(vs_at), 32'd1);
    v_start = 9'd0;
    v_end   = 9'd500;

    // Empty window: h_end below h_start
    h_end = 10'd100;
    run_line(800, 96, 1'b0, 1'b1);
    check("empty_active", 32'(act_cnt), 32'd0);
    check("empty_colour", 32'(col_nz), 32'd0);
    h_end = 10'd784;

    // hsync arriving mid-active at hcnt=300
    run_line(800, 96, 1'b0, 1'b1);
    run_line(301, 96, 1'b0, 1'b1);
    check("early_pre_hblank", 32'(hblank), 32'd0);
    run_line(1, 1, 1'b0, 1'b1);
    check("early_hblank", 32'(hblank), 32'd1);
    check("early_hs_out", 32'(hs_out), 32'd0);
    run_line(799, 95, 1'b0, 1'b1);
    check("early_line_len", 32'(line_len), 32'd301);
    run_line(800, 96, 1'b0, 1'b1);
    check("after_line_len", 32'(line_len), 32'd800);

    // hsync missing for 2000 pixels
    run_line(2000, 0, 1'b0, 1'b1);
    check("nohs_active", 32'(act_cnt), 32'd0);
    check("nohs_hblank", 32'(hblank), 32'd1);
    check("nohs_line_len", 32'(line_len), 32'd800);
    run_line(800, 96, 1'b0, 1'b1);
    check("sat_line_len", 32'(line_len), 32'd800);
    check("resync_active", 32'(act_cnt), 32'd640);

    // ce_pix low holds outputs
    run_line(400, 96, 1'b0, 1'b1);
    ce_pix = 1'b0;
    r_in   = 6'h15;
    hs_in  = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    check("hold_r_out", 32'(r_out), 32'h2A);
    check("hold_hs_out", 32'(hs_out), 32'd1);
    check("hold_hblank", 32'(hblank), 32'd0);
    r_in  = 6'h2A;
    hs_in = 1'b1;

    // Reset mid-active line
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_r_out", 32'(r_out), 32'd0);
    check("mid_rst_hblank", 32'(hblank), 32'd1);
    check("mid_rst_hs_out", 32'(hs_out), 32'd1);
    check("mid_rst_line_len", 32'(line_len), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    run_line(400, 0, 1'b0, 1'b1);
    check("post_rst_active", 32'(act_cnt), 32'd0);
    run_line(800, 96, 1'b0, 1'b1);
    check("post_rst_line", 32'(act_cnt), 32'd640);
    check("post_rst_colour", 32'(r_at), 32'h2A);

`ifdef MIST_BLANK_GEN_POLARITY_DETECT_EN
    // Inverted hsync: high for 96 of 800
    for (int n = 0; n < 5; n++) run_line(800, 96, 1'b1, 1'b1);
    check("inv_hs_low", 32'(hsl_cnt), 32'd96);
    check("inv_active", 32'(act_cnt), 32'd640);
    run_line(10, 96, 1'b1, 1'b1);
    check("inv_line_len", 32'(line_len), 32'd800);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
